// File: rtl/pc_sequencer.sv
// Purpose : program-counter sequencer (IDLE/RUN/DONE) with increment, signed relative
//           branch and table-indexed absolute jump, plus start/done handshake.
// Latency : pc/flags/icount update one edge after the controlling inputs; lut_addr_o is combinational.
// Backpressure: stall_i freezes pc and icount in RUN; start_i is honoured only in IDLE or DONE.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   start_i, prog_sel_i       launch program at table entry prog_sel_i (IDLE/DONE only)
//   stall_i, halt_i           RUN-time freeze and halt-instruction indication
//   jump_en_i, jump_idx_i     absolute jump through the external target table
//   branch_en_i, branch_taken_i, branch_off_i   signed relative branch
//   lut_addr_o / lut_target_i address to / target from the external table
//   pc_o, pc_valid_o, busy_o, done_o, icount_o  registered status outputs
module pc_sequencer #(
    parameter int D  = 12,
    parameter int IW = 4,
    parameter int OW = 8,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [IW-1:0] prog_sel_i,
    input  logic          stall_i,
    input  logic          halt_i,
    input  logic          jump_en_i,
    input  logic [IW-1:0] jump_idx_i,
    input  logic          branch_en_i,
    input  logic          branch_taken_i,
    input  logic [OW-1:0] branch_off_i,
    output logic [IW-1:0] lut_addr_o,
    input  logic [D-1:0]  lut_target_i,
    output logic [D-1:0]  pc_o,
    output logic          pc_valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] icount_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] icount_q, icount_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [D-1:0]  branch_off_sx;
    logic [CW-1:0] icount_inc;

    // The table is combinational, so its address must already select the
    // jump target during RUN to capture it at the deciding edge.
    assign lut_addr_o = (state_q == ST_RUN) ? jump_idx_i : prog_sel_i;

    // Two's-complement offset widened to pc width; the add then wraps mod 2^D.
    assign branch_off_sx = {{(D-OW){branch_off_i[OW-1]}}, branch_off_i};

    // Retired-instruction count sticks at all-ones instead of wrapping.
    assign icount_inc = (icount_q == {CW{1'b1}}) ? icount_q : icount_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        busy_d   = busy_q;
        done_d   = done_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    pc_d     = lut_target_i;
                    icount_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (stall_i) begin
                    // Everything, including a pending halt, waits for the stall to clear.
                    state_d = ST_RUN;
                end else if (halt_i) begin
                    state_d  = ST_DONE;
                    icount_d = icount_inc;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (jump_en_i) begin
                    pc_d     = lut_target_i;
                    icount_d = icount_inc;
                end else if (branch_en_i && branch_taken_i) begin
                    pc_d     = pc_q + branch_off_sx;
                    icount_d = icount_inc;
                end else begin
                    pc_d     = pc_q + 1'b1;
                    icount_d = icount_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            icount_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // pc_valid and busy are the same RUN indication.
    assign pc_o       = pc_q;
    assign pc_valid_o = busy_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign icount_o   = icount_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : directed self-checking bench for pc_sequencer with a modelled jump table.
// Latency : inputs driven 1 time unit after a rising edge, outputs checked 1 unit after the next.
// Backpressure: stall is exercised together with halt; no other flow control.
module tb_pc_sequencer;

    localparam int D  = 12;
    localparam int IW = 4;
    localparam int OW = 8;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [IW-1:0] prog_sel_i;
    logic          stall_i;
    logic          halt_i;
    logic          jump_en_i;
    logic [IW-1:0] jump_idx_i;
    logic          branch_en_i;
    logic          branch_taken_i;
    logic [OW-1:0] branch_off_i;
    logic [IW-1:0] lut_addr_o;
    logic [D-1:0]  lut_target_i;
    logic [D-1:0]  pc_o;
    logic          pc_valid_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] icount_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    // Jump-target table: 0->1, 1->18, 3->54, everything else 31.
    always_comb begin
        case (lut_addr_o)
            4'd0:    lut_target_i = 12'd1;
            4'd1:    lut_target_i = 12'd18;
            4'd3:    lut_target_i = 12'd54;
            default: lut_target_i = 12'd31;
        endcase
    end

    pc_sequencer #(.D(D), .IW(IW), .OW(OW), .CW(CW)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .prog_sel_i     (prog_sel_i),
        .stall_i        (stall_i),
        .halt_i         (halt_i),
        .jump_en_i      (jump_en_i),
        .jump_idx_i     (jump_idx_i),
        .branch_en_i    (branch_en_i),
        .branch_taken_i (branch_taken_i),
        .branch_off_i   (branch_off_i),
        .lut_addr_o     (lut_addr_o),
        .lut_target_i   (lut_target_i),
        .pc_o           (pc_o),
        .pc_valid_o     (pc_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .icount_o       (icount_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; outputs settle 1 unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_ctl();
        start_i        = 1'b0;
        stall_i        = 1'b0;
        halt_i         = 1'b0;
        jump_en_i      = 1'b0;
        jump_idx_i     = '0;
        branch_en_i    = 1'b0;
        branch_taken_i = 1'b0;
        branch_off_i   = '0;
    endtask

    task automatic chk_run(input string tag, input logic [D-1:0] pc_e, input logic [CW-1:0] ic_e);
        chk({tag, "_pc"}, 32'(pc_o), 32'(pc_e));
        chk({tag, "_ic"}, 32'(icount_o), 32'(ic_e));
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pc"}, 32'(pc_o), 32'd0);
        chk({tag, "_ic"}, 32'(icount_o), 32'd0);
        chk({tag, "_vld"}, 32'(pc_valid_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        clear_ctl();
        reset_i    = 1'b1;
        prog_sel_i = 4'd1;
        step();
        step();
        reset_i = 1'b0;
        step();
        chk_idle("rst");
        chk("idle_lut_addr", 32'(lut_addr_o), 32'd1);

        // Start program 1 -> entry 18.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk_run("start", 12'd18, 16'd0);
        chk("start_vld", 32'(pc_valid_o), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_run("inc", 12'(18 + i), 16'(i));
        end

        // Absolute jump through entry 3.
        jump_en_i  = 1'b1;
        jump_idx_i = 4'd3;
        #1;
        chk("run_lut_addr", 32'(lut_addr_o), 32'd3);
        step();
        jump_en_i = 1'b0;
        chk_run("jump", 12'd54, 16'd4);

        // Taken branch -5, then not-taken branch.
        branch_en_i    = 1'b1;
        branch_taken_i = 1'b1;
        branch_off_i   = 8'hFB;
        step();
        chk_run("br_taken", 12'd49, 16'd5);
        branch_taken_i = 1'b0;
        step();
        chk_run("br_ntaken", 12'd50, 16'd6);

        // 50 - 51 wraps to 0xFFF, then increment wraps to 0.
        branch_taken_i = 1'b1;
        branch_off_i   = 8'hCD;
        step();
        chk_run("br_wrap_neg", 12'hFFF, 16'd7);
        clear_ctl();
        step();
        chk_run("inc_wrap", 12'h000, 16'd8);
        for (int i = 0; i < 4; i++) step();
        chk_run("inc_to4", 12'h004, 16'd12);

        // 0x004 + (-5) -> 0xFFF; 0xFFF - 15 -> 0xFF0; 0xFF0 + 0x14 -> 0x004.
        branch_en_i    = 1'b1;
        branch_taken_i = 1'b1;
        branch_off_i   = 8'hFB;
        step();
        chk_run("br_4m5", 12'hFFF, 16'd13);
        branch_off_i = 8'hF1;
        step();
        chk_run("br_m15", 12'hFF0, 16'd14);
        branch_off_i = 8'h14;
        step();
        chk_run("br_fwd_wrap", 12'h004, 16'd15);
        clear_ctl();

        // start during RUN is ignored.
        start_i    = 1'b1;
        prog_sel_i = 4'd0;
        step();
        start_i = 1'b0;
        chk_run("start_in_run", 12'h005, 16'd16);

        // Jump and branch together: jump wins.
        jump_en_i      = 1'b1;
        jump_idx_i     = 4'd1;
        branch_en_i    = 1'b1;
        branch_taken_i = 1'b1;
        branch_off_i   = 8'h10;
        step();
        clear_ctl();
        chk_run("jump_prio", 12'd18, 16'd17);

        // Stall masks halt (and a jump) for two cycles.
        stall_i   = 1'b1;
        halt_i    = 1'b1;
        jump_en_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_run("stall", 12'd18, 16'd17);
            chk("stall_done", 32'(done_o), 32'd0);
        end
        stall_i   = 1'b0;
        jump_en_i = 1'b0;
        step();
        halt_i = 1'b0;
        chk("halt_done", 32'(done_o), 32'd1);
        chk("halt_busy", 32'(busy_o), 32'd0);
        chk("halt_vld", 32'(pc_valid_o), 32'd0);
        chk("halt_pc", 32'(pc_o), 32'd18);
        chk("halt_ic", 32'(icount_o), 32'd18);

        // DONE holds and ignores RUN controls.
        jump_en_i  = 1'b1;
        jump_idx_i = 4'd3;
        step();
        step();
        clear_ctl();
        chk("done_hold", 32'(done_o), 32'd1);
        chk("done_hold_pc", 32'(pc_o), 32'd18);
        chk("done_hold_ic", 32'(icount_o), 32'd18);

        // Restart from DONE with program 0 -> entry 1.
        prog_sel_i = 4'd0;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        chk_run("restart", 12'd1, 16'd0);
        chk("restart_done", 32'(done_o), 32'd0);

        // Reset in the middle of a jump.
        jump_en_i  = 1'b1;
        jump_idx_i = 4'd3;
        reset_i    = 1'b1;
        step();
        reset_i = 1'b0;
        clear_ctl();
        chk_idle("mid_rst");
        step();
        chk_idle("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle core. It owns the `pc` register, starts a program at a table-selected entry point, and advances `pc` by increment, signed relative branch or table-indexed absolute jump. It also handles stall, halt and a start/done handshake with the test harness. It drives the address of the absolute-jump target table and consumes that table's combinational target output; the table itself is external.

## Interface
- `D`, 12, PC / instruction-address width.
- `IW`, 4, jump-table index width (16 entries).
- `OW`, 8, relative-branch offset width (two's complement).
- `CW`, 16, executed-instruction counter width.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin the program selected by `prog_sel`; honoured only in IDLE or DONE.
- `prog_sel`  in  IW  jump-table index of the program entry point.
- `stall`  in  1  freeze `pc` and counter this cycle (RUN only).
- `halt`  in  1  current instruction is a halt.
- `jump_en`  in  1  absolute jump via table.
- `jump_idx`  in  IW  table index for the jump.
- `branch_en`  in  1  relative branch instruction.
- `branch_taken`  in  1  branch condition true.
- `branch_off`  in  OW  signed branch offset.
- `lut_addr`  out  IW  address to the jump-target table (combinational).
- `lut_target`  in  D  table output for `lut_addr` (combinational).
- `pc`  out  D  current instruction address.
- `pc_valid`  out  1  high in RUN: `pc` addresses a live instruction.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `icount`  out  CW  instructions retired since last start; saturating.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE; `pc`=0; `icount`=0; `pc_valid`=`busy`=`done`=0.
- `lut_addr` = `prog_sel` in IDLE/DONE, `jump_idx` in RUN.
- IDLE/DONE with `start`=1: `pc` <= `lut_target`, `icount` <= 0, go to RUN. Without `start`, state and `pc` hold.
- In DONE, `done` stays high until `start` or `reset`.
- RUN next-`pc` priority, top first:
  1. `stall`=1: hold everything. A `halt`, jump or branch presented during the stall is ignored.
  2. `halt`=1: go to DONE; `pc` holds; `icount` += 1.
  3. `jump_en`=1: `pc` <= `lut_target`.
  4. `branch_en` & `branch_taken`: `pc` <= `pc` + signext(`branch_off`).
  5. Otherwise, including a not-taken branch: `pc` <= `pc` + 1.
- Cases 3-5 also do `icount` += 1.
- Arithmetic is modulo 2^D:
  - 0xFFF + 1 -> 0x000.
  - 0x004 + (-5) -> 0xFFF.
  - 0xFF0 + 0x14 -> 0x004.
- `icount` saturates at 2^CW-1.
- `start` in RUN is ignored.
- `jump_en` and `branch_en` both high: jump wins.
- Inputs other than `start`/`prog_sel` are ignored outside RUN.
- `reset` overrides everything in any state, mid-program included; next cycle is the IDLE reset state.

## Timing
- `lut_addr` is combinational from state and inputs. The table is combinational, so the target is captured at the same edge that decides the jump: zero-bubble jumps.
- `pc` updates one edge after the controlling inputs. The first RUN cycle presents the entry address.
- Latency from `start` sampled to `pc_valid`=1: 1 cycle.
- Latency from `halt` sampled to `done`=1: 1 cycle.
- `pc_valid` and `busy` drop in the same cycle `done` rises.
- Outputs `pc`, `pc_valid`, `busy`, `done`, `icount` are registered or state-decoded. No combinational path from inputs to them.

## Test plan
The bench models the table as index 0->1, 1->18, 3->54, others 31.
- Reset then `start` with `prog_sel`=1 -> next cycle `pc`=18, `busy`=1. Three idle cycles -> `pc` = 19, 20, 21; `icount`=3.
- In RUN at `pc`=21, `jump_en`=1, `jump_idx`=3 -> `pc`=54. Next cycle `branch_en`=`branch_taken`=1, `branch_off`=0xFB -> `pc`=49. Not-taken branch -> `pc`=50.
- `pc`=0xFFF with no control -> `pc`=0x000. `pc`=0x004 with `branch_off`=-5 -> 0xFFF.
- `stall`=1 together with `halt`=1 for 2 cycles -> `pc` and `icount` unchanged, still RUN. Drop `stall` with `halt` held -> `done`=1 next cycle, `pc` held.
- In DONE, `start` with `prog_sel`=0 -> `pc`=1, `icount`=0, `done`=0. `start` pulsed mid-RUN -> no effect.
- Assert `reset` mid-jump -> next cycle `pc`=0, IDLE, all flags 0. Both `jump_en` and `branch_en` high -> jump target taken.
